// File: rtl/mem_burst_scheduler_if.sv
// Requester-side bundle of the memory burst scheduler: request handshake plus
// the shared read-response bus.
interface mem_burst_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 16
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        req_we;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/mem_burst_scheduler.sv
// Round-robin SRAM scheduler with burst locking, a registered memory command
// stage and a fixed-latency tag pipeline that routes read data back to its issuer.
module mem_burst_scheduler #(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 16,
  parameter int RD_LAT    = 1,
  parameter int MAX_BURST = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  mem_burst_scheduler_if.slave       bus,
  output logic                       mem_ce,
  output logic                       mem_we,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  input  logic [DATA_W-1:0]          mem_rdata,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = 4;

  logic [ID_W-1:0]    rr_ptr_r, owner_r, grant_id_r;
  logic               lock_r;
  logic [CNT_W-1:0]   beat_cnt_r;
  logic               mem_ce_r, mem_we_r;
  logic [ADDR_W-1:0]  mem_addr_r;
  logic [DATA_W-1:0]  mem_wdata_r;
  logic [RD_LAT:0]    tag_vld_r;
  logic [ID_W-1:0]    tag_id_r [RD_LAT+1];

  logic               lock_win_s, win_vld_s, accept_s;
  logic [ID_W-1:0]    win_idx_s, rr_next_s;
  logic [CNT_W-1:0]   beat_next_s;
  logic [NUM_REQ-1:0] ready_s, rsp_valid_s;
  logic [DATA_W-1:0]  rsp_rdata_s;

  // First valid requester found scanning ptr, ptr+1, ... (wrapping); MSB flags a hit.
  function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] vld,
                                            input logic [ID_W-1:0]    ptr);
    logic [ID_W:0] pick;
    int            cand;
    pick = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = (int'(ptr) + k) % NUM_REQ;
      if (vld[cand]) begin
        pick = {1'b1, ID_W'(cand)};
      end else begin
        pick = pick;
      end
    end
    return pick;
  endfunction

  // Arbitration: a live burst lock beats the round-robin search.
  always_comb begin
    win_vld_s  = 1'b0;
    win_idx_s  = '0;
    lock_win_s = lock_r & bus.req_valid[owner_r] & (beat_cnt_r < CNT_W'(MAX_BURST));
    if (lock_win_s) begin
      win_vld_s = 1'b1;
      win_idx_s = owner_r;
    end else begin
      {win_vld_s, win_idx_s} = rr_pick(bus.req_valid, rr_ptr_r);
    end
    accept_s    = win_vld_s & ~rst;
    beat_next_s = lock_win_s ? (beat_cnt_r + CNT_W'(1)) : CNT_W'(1);
    rr_next_s   = (win_idx_s == ID_W'(NUM_REQ - 1)) ? '0 : (win_idx_s + ID_W'(1));
  end

  // One-hot ready for the winner, suppressed while reset is asserted.
  always_comb begin
    ready_s = '0;
    if (accept_s) begin
      ready_s[win_idx_s] = 1'b1;
    end else begin
      ready_s = '0;
    end
  end

  // Arbiter state and the registered memory command.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_r    <= '0;
      owner_r     <= '0;
      lock_r      <= 1'b0;
      beat_cnt_r  <= '0;
      grant_id_r  <= '0;
      mem_ce_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
    end else begin
      mem_ce_r <= accept_s;
      mem_we_r <= accept_s & bus.req_we[win_idx_s];
      if (accept_s) begin
        owner_r     <= win_idx_s;
        lock_r      <= 1'b1;
        beat_cnt_r  <= beat_next_s;
        rr_ptr_r    <= rr_next_s;
        grant_id_r  <= win_idx_s;
        mem_addr_r  <= bus.req_addr[win_idx_s*ADDR_W +: ADDR_W];
        mem_wdata_r <= bus.req_wdata[win_idx_s*DATA_W +: DATA_W];
      end else begin
        lock_r     <= 1'b0;
        beat_cnt_r <= '0;
      end
    end
  end

  // Tag pipeline: stage RD_LAT lines up with mem_rdata of the matching read.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld_r <= '0;
      for (int k = 0; k <= RD_LAT; k++) tag_id_r[k] <= '0;
    end else begin
      tag_vld_r[0] <= accept_s & ~bus.req_we[win_idx_s];
      tag_id_r[0]  <= win_idx_s;
      for (int k = 1; k <= RD_LAT; k++) begin
        tag_vld_r[k] <= tag_vld_r[k-1];
        tag_id_r[k]  <= tag_id_r[k-1];
      end
    end
  end

  // Read return: route pass-through SRAM data to the issuing requester.
  always_comb begin
    rsp_valid_s = '0;
    rsp_rdata_s = '0;
    if (tag_vld_r[RD_LAT]) begin
      rsp_valid_s[tag_id_r[RD_LAT]] = 1'b1;
      rsp_rdata_s                   = mem_rdata;
    end else begin
      rsp_valid_s = '0;
      rsp_rdata_s = '0;
    end
  end

  assign bus.req_ready = ready_s;
  assign bus.rsp_valid = rsp_valid_s;
  assign bus.rsp_rdata = rsp_rdata_s;
  assign mem_ce        = mem_ce_r;
  assign mem_we        = mem_we_r;
  assign mem_addr      = mem_addr_r;
  assign mem_wdata     = mem_wdata_r;
  assign grant_id      = grant_id_r;
endmodule
